gcd_requester: RTL and testbench
================================

// Module: gcd_requester
// PURPOSE
//   Initiator for the gcd_top core. Accepts operand pairs on an upstream valid/ready port,
//   issues each pair to the core (start pulse, operands held stable) and waits for done.
//   Returns the result, or an error on timeout, on a downstream valid/ready port.
//   Sits between the operand producer and gcd_top. Zero operands are resolved locally.
// PARAMETERS
//   WIDTH    8    operand/result width in bits
//   TIMEOUT  255  max cycles in WAIT before error (>=1); wait counter is $clog2(TIMEOUT+1) bits
// PORTS
//   clk          in   1      single clock, all logic on rising edge
//   reset        in   1      synchronous, active-high; sampled on rising clk
//   in_valid     in   1      upstream operand pair valid
//   in_ready     out  1      requester can accept a pair
//   in_a         in   WIDTH  operand A
//   in_b         in   WIDTH  operand B
//   core_start   out  1      one-cycle start pulse to gcd_top
//   core_a       out  WIDTH  operand A to core, stable from ISSUE until leaving WAIT
//   core_b       out  WIDTH  operand B to core, same rule as core_a
//   core_result  in   WIDTH  core result, valid when core_done=1
//   core_done    in   1      core completion, one-cycle pulse
//   out_valid    out  1      result available
//   out_ready    in   1      downstream accepts result
//   out_result   out  WIDTH  gcd(a,b); 0 when out_err=1
//   out_err      out  1      1 = core timed out
//   done_count   out  16     completed transactions (ok + err), wraps 0xFFFF->0
//   err_count    out  16     timed-out transactions, wraps 0xFFFF->0
// BEHAVIOUR
//   Reset: state=IDLE; in_ready=0 during reset cycle, 1 the cycle after.
//     All other outputs 0, both counters 0, wait counter 0. Reset mid-transaction aborts it.
//     No result is emitted for an aborted transaction; a late core_done is ignored.
//   FSM IDLE -> ISSUE -> WAIT -> OUT -> IDLE; IDLE -> OUT (bypass).
//   IDLE: in_ready=1. Accept on in_valid&&in_ready: latch a,b.
//     If a==0 or b==0 -> OUT with result=a|b (gcd(0,0)=0), err=0. No core_start is issued.
//     Else -> ISSUE.
//   ISSUE: core_start=1 for exactly this cycle; core_a/core_b driven from latches.
//     Wait counter cleared. Next state WAIT.
//   WAIT: core_start=0; counter increments each cycle.
//     core_done=1 -> capture core_result, err=0, -> OUT.
//     Else if counter==TIMEOUT-1 -> result=0, err=1, -> OUT.
//     core_done and timeout in the same cycle: done wins.
//   OUT: out_valid=1; out_result/out_err held stable until out_ready=1.
//     On accept: done_count+1, err_count+1 if err, -> IDLE.
//     Next pair is accepted no earlier than the cycle after the IDLE return (no overlap).
//   in_ready=0 outside IDLE. core_done outside WAIT is ignored.
//   Operands are held in latches; in_a/in_b changes after acceptance have no effect.
//   Latency (out_ready=1):
//     bypass: out_valid the cycle after accept.
//     core: core_start the cycle after accept; out_valid the cycle after core_done.
//   Throughput: one transaction at a time; the minimum core-path cycle is 4 clocks plus core latency.
// TESTING
//   1 a=64,b=8, core model done 6 cycles after start=8 -> one core_start pulse;
//     out_result=8, out_err=0, done_count=1.
//   2 a=32,b=4 back-to-back after test 1 -> out_result=4; in_ready low from accept to IDLE return.
//   3 a=0,b=9 then a=0,b=0 -> results 9 and 0 one cycle after accept; core_start never asserts.
//   4 core model never asserts done, TIMEOUT=16 -> out_valid 16 cycles after WAIT entry.
//     Expect out_err=1, out_result=0, err_count=1.
//   5 out_ready low 5 cycles in OUT -> out_valid/out_result stable; in_ready=0; no count change.
//   6 reset asserted mid-WAIT, core_done pulses after release -> no out_valid; counters 0;
//     in_ready=1 the cycle after reset deasserts.

Source files
------------

// File: rtl/gcd_requester_if.sv
// Handshake bundle for gcd_requester: upstream operands, core issue/complete, downstream result.
// slave = requester side, master = producer/core/consumer environment side.
interface gcd_requester_if #(
   parameter int unsigned WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             core_start;
   logic [WIDTH-1:0] core_a;
   logic [WIDTH-1:0] core_b;
   logic [WIDTH-1:0] core_result;
   logic             core_done;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_result;
   logic             out_err;
   logic [15:0]      done_count;
   logic [15:0]      err_count;

   modport slave (
      input  in_valid, in_a, in_b, core_result, core_done, out_ready,
      output in_ready, core_start, core_a, core_b, out_valid, out_result, out_err,
      output done_count, err_count
   );

   modport master (
      output in_valid, in_a, in_b, core_result, core_done, out_ready,
      input  in_ready, core_start, core_a, core_b, out_valid, out_result, out_err,
      input  done_count, err_count
   );
endinterface

// File: rtl/gcd_requester.sv
// Initiator for gcd_top: accepts operand pairs, issues them to the core, waits for done
// or timeout, and returns the result; zero operands are resolved locally without the core.
module gcd_requester #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            reset,
   gcd_requester_if.slave  bus
);

   localparam int unsigned   CW   = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      OUT
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, b_q, result_q;
   logic             err_q;
   logic [CW-1:0]    wait_cnt;
   logic [15:0]      done_cnt_q, err_cnt_q;
   logic             zero_op;
   logic             timeout_hit;

   assign zero_op     = (bus.in_a == '0) || (bus.in_b == '0);
   assign timeout_hit = (wait_cnt == LAST);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (bus.in_valid) state_d = zero_op ? OUT : ISSUE;
         ISSUE: state_d = WAIT;
         WAIT:  if (bus.core_done || timeout_hit) state_d = OUT;
         OUT:   if (bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         a_q        <= '0;
         b_q        <= '0;
         result_q   <= '0;
         err_q      <= 1'b0;
         wait_cnt   <= '0;
         done_cnt_q <= '0;
         err_cnt_q  <= '0;
      end else begin
         state_q <= state_d;
         unique case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  a_q <= bus.in_a;
                  b_q <= bus.in_b;
                  // gcd(x,0)=x and gcd(0,0)=0, so the OR covers every zero case
                  if (zero_op) begin
                     result_q <= bus.in_a | bus.in_b;
                     err_q    <= 1'b0;
                  end
               end
            end
            ISSUE: wait_cnt <= '0;
            WAIT: begin
               wait_cnt <= wait_cnt + 1'b1;
               if (bus.core_done) begin
                  result_q <= bus.core_result;
                  err_q    <= 1'b0;
               end else if (timeout_hit) begin
                  result_q <= '0;
                  err_q    <= 1'b1;
               end
            end
            OUT: begin
               if (bus.out_ready) begin
                  done_cnt_q <= done_cnt_q + 16'd1;
                  if (err_q) err_cnt_q <= err_cnt_q + 16'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready   = (state_q == IDLE) && !reset;
   assign bus.core_start = (state_q == ISSUE);
   assign bus.core_a     = a_q;
   assign bus.core_b     = b_q;
   assign bus.out_valid  = (state_q == OUT);
   assign bus.out_result = result_q;
   assign bus.out_err    = err_q;
   assign bus.done_count = done_cnt_q;
   assign bus.err_count  = err_cnt_q;

endmodule

// File: tb/tb_gcd_requester.sv
// Directed bench for gcd_requester: vector table of transactions plus reset and stall sequences,
// with a behavioural gcd_top stand-in whose done latency is set per vector.
module tb_gcd_requester;

   logic clk;
   logic reset;

   gcd_requester_if #(.WIDTH(8)) bus ();

   gcd_requester #(.WIDTH(8), .TIMEOUT(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] gcd8(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] x, y, t;
      x = a;
      y = b;
      while (y != 8'd0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   // Core stand-in: done pulses core_lat cycles after the start pulse, if enabled
   bit         core_en;
   int         core_lat;
   int         core_cnt;
   logic       model_done;
   logic       manual_done;
   logic [7:0] model_result;

   assign bus.core_done   = model_done | manual_done;
   assign bus.core_result = model_result;

   initial begin
      model_done   = 1'b0;
      model_result = 8'd0;
      core_cnt     = 0;
   end

   always @(negedge clk) begin
      model_done = 1'b0;
      if (reset) begin
         core_cnt = 0;
      end else if (bus.core_start && core_en) begin
         core_cnt     = core_lat;
         model_result = gcd8(bus.core_a, bus.core_b);
      end else if (core_cnt > 0) begin
         core_cnt--;
         if (core_cnt == 0) model_done = 1'b1;
      end
   end

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      bit         core_en;
      int         core_lat;
      int         hold;
      logic [7:0] res;
      bit         err;
      int         lat;
      int         starts;
   } vec_t;

   vec_t vecs[11];
   int   exp_done;
   int   exp_errc;

   // Runs one transaction; entered and left at a negedge with state IDLE
   task automatic run(input vec_t v, input int idx);
      int  n;
      int  starts;
      bit  busy_ok;
      string tag;
      tag      = $sformatf("v%0d", idx);
      core_en  = v.core_en;
      core_lat = v.core_lat;
      check({tag, "_in_ready_idle"}, 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1;
      bus.in_a     = v.a;
      bus.in_b     = v.b;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_a     = 8'($urandom);
      bus.in_b     = 8'($urandom);
      n       = 1;
      starts  = 0;
      busy_ok = 1'b1;
      while (!bus.out_valid && n < 100) begin
         if (bus.core_start) starts++;
         if (bus.in_ready) busy_ok = 1'b0;
         @(negedge clk);
         n++;
      end
      check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, "_latency"}, 32'(n), 32'(v.lat));
      check({tag, "_start_pulses"}, 32'(starts), 32'(v.starts));
      check({tag, "_in_ready_busy"}, 32'(busy_ok), 32'd1);
      check({tag, "_result"}, 32'(bus.out_result), 32'(v.res));
      check({tag, "_err"}, 32'(bus.out_err), 32'(v.err));
      for (int h = 0; h < v.hold; h++) begin
         @(negedge clk);
         check({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
         check({tag, "_hold_result"}, 32'(bus.out_result), 32'(v.res));
         check({tag, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
         check({tag, "_hold_done_count"}, 32'(bus.done_count), 32'(exp_done));
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      exp_done++;
      if (v.err) exp_errc++;
      check({tag, "_valid_dropped"}, 32'(bus.out_valid), 32'd0);
      check({tag, "_done_count"}, 32'(bus.done_count), 32'(exp_done));
      check({tag, "_err_count"}, 32'(bus.err_count), 32'(exp_errc));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //          a       b       en lat hold res     err lat starts
      vecs[0]  = '{8'd64,  8'd8,   1, 6,  0,   8'd8,   0,  8,  1};
      vecs[1]  = '{8'd32,  8'd4,   1, 3,  0,   8'd4,   0,  5,  1};
      vecs[2]  = '{8'd0,   8'd9,   1, 1,  0,   8'd9,   0,  1,  0};
      vecs[3]  = '{8'd0,   8'd0,   1, 1,  0,   8'd0,   0,  1,  0};
      vecs[4]  = '{8'd10,  8'd4,   0, 0,  0,   8'd0,   1,  18, 1};
      vecs[5]  = '{8'd12,  8'd18,  1, 2,  5,   8'd6,   0,  4,  1};
      vecs[6]  = '{8'd255, 8'd17,  1, 16, 0,   8'd17,  0,  18, 1};
      vecs[7]  = '{8'd45,  8'd30,  1, 17, 0,   8'd0,   1,  18, 1};
      vecs[8]  = '{8'd9,   8'd0,   1, 1,  0,   8'd9,   0,  1,  0};
      vecs[9]  = '{8'd200, 8'd75,  1, 1,  0,   8'd25,  0,  3,  1};
      vecs[10] = '{8'd21,  8'd14,  1, 2,  0,   8'd7,   0,  4,  1};

      reset         = 1'b1;
      manual_done   = 1'b0;
      core_en       = 1'b0;
      core_lat      = 0;
      bus.in_valid  = 1'b0;
      bus.in_a      = 8'd0;
      bus.in_b      = 8'd0;
      bus.out_ready = 1'b0;
      exp_done      = 0;
      exp_errc      = 0;

      @(negedge clk);
      @(negedge clk);
      check("rst_in_ready", 32'(bus.in_ready), 32'd0);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_core_start", 32'(bus.core_start), 32'd0);
      check("rst_out_result", 32'(bus.out_result), 32'd0);
      check("rst_out_err", 32'(bus.out_err), 32'd0);
      check("rst_core_a", 32'(bus.core_a), 32'd0);
      check("rst_done_count", 32'(bus.done_count), 32'd0);
      check("rst_err_count", 32'(bus.err_count), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

      for (int i = 0; i < 10; i++) run(vecs[i], i);

      // Reset in the middle of WAIT; a late done must not produce a result
      core_en      = 1'b1;
      core_lat     = 10;
      bus.in_valid = 1'b1;
      bus.in_a     = 8'd20;
      bus.in_b     = 8'd8;
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      check("midwait_core_a", 32'(bus.core_a), 32'd20);
      reset = 1'b1;
      check("midwait_rst_in_ready_pre", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
      check("midwait_rst_in_ready", 32'(bus.in_ready), 32'd0);
      check("midwait_rst_done_count", 32'(bus.done_count), 32'd0);
      check("midwait_rst_err_count", 32'(bus.err_count), 32'd0);
      reset    = 1'b0;
      exp_done = 0;
      exp_errc = 0;
      @(negedge clk);
      check("midwait_post_in_ready", 32'(bus.in_ready), 32'd1);
      manual_done = 1'b1;
      @(negedge clk);
      manual_done = 1'b0;
      begin
         bit no_valid;
         no_valid = 1'b1;
         for (int k = 0; k < 6; k++) begin
            if (bus.out_valid || bus.core_start) no_valid = 1'b0;
            @(negedge clk);
         end
         check("midwait_late_done_ignored", 32'(no_valid), 32'd1);
      end
      check("midwait_idle_in_ready", 32'(bus.in_ready), 32'd1);
      check("midwait_counters", {bus.done_count, bus.err_count}, 32'd0);

      run(vecs[10], 10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
